// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer.
// Accepts two WIDTH-bit operands on start. Adds them one bit per clock
// through a single-bit full adder with a registered carry. Returns the sum and
// carry-out with a one-cycle done pulse.
// Optional feature macro: SERIAL_ADD_SUB_EN adds the sub port for subtraction
// (A - B, carry_out=1 means no borrow).
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic [CW-1:0]    r_cnt;
    logic             r_c;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_carry_out;

    logic             w_s1;
    logic             w_c1;
    logic             w_sum;
    logic             w_c2;
    logic             w_c_next;
    logic [WIDTH-1:0] w_b_cap;
    logic             w_c_init;

    // Single-bit full adder built from two half-add stages
    assign w_s1     = r_a[0] ^ r_b[0];
    assign w_c1     = r_a[0] & r_b[0];
    assign w_sum    = w_s1 ^ r_c;
    assign w_c2     = w_s1 & r_c;
    assign w_c_next = w_c1 | w_c2;

    // Operand B and carry seed at acceptance; subtract uses ~B + 1
`ifdef SERIAL_ADD_SUB_EN
    assign w_b_cap  = sub ? ~op_b : op_b;
    assign w_c_init = sub;
`else
    assign w_b_cap  = op_b;
    assign w_c_init = 1'b0;
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign carry_out = r_carry_out;

    // Sequencer FSM, serial datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_s         <= '0;
            r_cnt       <= '0;
            r_c         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= op_a;
                        r_b     <= w_b_cap;
                        r_c     <= w_c_init;
                        r_s     <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_s   <= {w_sum, r_s[WIDTH-1:1]};
                    r_c   <= w_c_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_BIT) begin
                        // Publish only the completed word; partial sums stay internal
                        r_result    <= {w_sum, r_s[WIDTH-1:1]};
                        r_carry_out <= w_c_next;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed testbench for serial_add_ctrl (WIDTH=8), expected values hand-computed.
module tb_serial_add_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;

    int n_checks = 0;
    int n_fail   = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample and drive 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle and wait (bounded) for done; then return to IDLE
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output logic [WIDTH-1:0] r, output logic co,
                         output logic timed_out);
        int k;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        op_a  = ~a;
        op_b  = ~b;
        timed_out = 1'b1;
        for (k = 0; k < 40; k++) begin
            tick();
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
        r  = result;
        co = carry_out;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
`ifdef SERIAL_ADD_SUB_EN
        sub   = 1'b0;
`endif
        #23;
        n_checks++;
        if ({busy, done, result, carry_out} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b result=%h carry_out=%b, expected all 0",
                     busy, done, result, carry_out);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_timing();
        int busy_cycles = 0;
        int done_at = -1;
        op_a  = 8'h3C;
        op_b  = 8'h5A;
        start = 1'b1;
        tick();
        start = 1'b0;
        op_a  = 8'hFF;
        op_b  = 8'hFF;
        for (int k = 1; k <= 12; k++) begin
            if (busy) busy_cycles++;
            if (done) begin
                if (done_at < 0) done_at = k - 1;
                else done_at = 99;
            end
            if (!done && k < 9) begin
                n_checks++;
                if (result !== 8'h00) begin
                    n_fail++;
                    $display("FAIL basic_no_early_result: cycle %0d result=%h, expected 00", k, result);
                end
            end
            tick();
        end
        n_checks++;
        if (busy_cycles != 9) begin
            n_fail++;
            $display("FAIL basic_busy_len: busy cycles=%0d, expected 9", busy_cycles);
        end
        n_checks++;
        if (done_at != 8) begin
            n_fail++;
            $display("FAIL basic_done_edge: done seen after edge %0d, expected 8 (single pulse)", done_at);
        end
        n_checks++;
        if (result !== 8'h96 || carry_out !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: result=%h carry_out=%b, expected 96/0", result, carry_out);
        end
    endtask

    task automatic test_carry();
        logic [WIDTH-1:0] r;
        logic co, to;
        do_op(8'hFF, 8'h01, r, co, to);
        n_checks++;
        if (to || r !== 8'h00 || co !== 1'b1) begin
            n_fail++;
            $display("FAIL carry_ff_01: result=%h carry_out=%b timeout=%b, expected 00/1/0", r, co, to);
        end
        do_op(8'h00, 8'h00, r, co, to);
        n_checks++;
        if (to || r !== 8'h00 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL carry_00_00: result=%h carry_out=%b timeout=%b, expected 00/0/0", r, co, to);
        end
    endtask

    task automatic test_start_ignored();
        int pulses = 0;
        op_a  = 8'h11;
        op_b  = 8'h22;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        op_a  = 8'h77;
        op_b  = 8'h77;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (done) pulses++;
            tick();
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL ignore_pulses: done pulses=%0d, expected 1", pulses);
        end
        n_checks++;
        if (result !== 8'h33 || carry_out !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_result: result=%h carry_out=%b, expected 33/0", result, carry_out);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_idle: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_reset_midrun();
        logic [WIDTH-1:0] r;
        logic co, to;
        op_a  = 8'hF0;
        op_b  = 8'h0F;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, result, carry_out} !== 11'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: busy=%b done=%b result=%h carry_out=%b, expected all 0",
                     busy, done, result, carry_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || result !== 8'h00) begin
            n_fail++;
            $display("FAIL midrun_discard: busy=%b result=%h, expected 0/00", busy, result);
        end
        do_op(8'h01, 8'h01, r, co, to);
        n_checks++;
        if (to || r !== 8'h02 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_op: result=%h carry_out=%b timeout=%b, expected 02/0/0", r, co, to);
        end
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_subtract();
        logic [WIDTH-1:0] r;
        logic co, to;
        sub = 1'b1;
        do_op(8'h10, 8'h01, r, co, to);
        n_checks++;
        if (to || r !== 8'h0F || co !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_10_01: result=%h carry_out=%b timeout=%b, expected 0F/1/0", r, co, to);
        end
        do_op(8'h01, 8'h02, r, co, to);
        n_checks++;
        if (to || r !== 8'hFF || co !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_01_02: result=%h carry_out=%b timeout=%b, expected FF/0/0", r, co, to);
        end
        sub = 1'b0;
        do_op(8'h01, 8'h02, r, co, to);
        n_checks++;
        if (to || r !== 8'h03 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL sub0_add: result=%h carry_out=%b timeout=%b, expected 03/0/0", r, co, to);
        end
    endtask
`endif

    task automatic test_back_to_back();
        int pulses = 0;
        int last = -1;
        op_a  = 8'h80;
        op_b  = 8'h80;
        start = 1'b1;
        for (int k = 0; k < 35; k++) begin
            tick();
            if (done) begin
                pulses++;
                n_checks++;
                if (result !== 8'h00 || carry_out !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_result: cycle %0d result=%h carry_out=%b, expected 00/1",
                             k, result, carry_out);
                end
                if (last >= 0) begin
                    n_checks++;
                    if (k - last != 10) begin
                        n_fail++;
                        $display("FAIL b2b_period: interval=%0d, expected 10", k - last);
                    end
                end
                last = k;
            end
        end
        start = 1'b0;
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL b2b_count: done pulses=%0d, expected 3", pulses);
        end
        for (int k = 0; k < 12; k++) tick();
    endtask

    initial begin
        test_reset();
        test_basic_timing();
        test_carry();
        test_start_ignored();
        test_reset_midrun();
`ifdef SERIAL_ADD_SUB_EN
        test_subtract();
`endif
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
